// File: rtl/lcd_pkg.sv
// Shared state encoding, init ROM contents and timing helper for the HD44780 sequencer.
// LCD_4BIT_EN adds the second-nibble state and the nibble-mode init ROM.
package lcd_pkg;

    localparam logic [2:0] ST_PWR_WAIT = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_STROBE   = 3'd2;
    localparam logic [2:0] ST_WAIT_FIN = 3'd3;
    localparam logic [2:0] ST_DELAY    = 3'd4;
    localparam logic [2:0] ST_IDLE     = 3'd5;
    localparam logic [2:0] ST_NIB2     = 3'd6;

    typedef enum logic [2:0] {
        S_PWR_WAIT = ST_PWR_WAIT,
        S_LOAD     = ST_LOAD,
        S_STROBE   = ST_STROBE,
        S_WAIT_FIN = ST_WAIT_FIN,
        S_DELAY    = ST_DELAY,
        S_IDLE     = ST_IDLE
`ifdef LCD_4BIT_EN
        , S_NIB2   = ST_NIB2
`endif
    } state_t;

    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;

    localparam int unsigned INIT_LEN_8 = 8;
    localparam int unsigned INIT_LEN_4 = 9;

    function automatic logic [7:0] init_rom_8(input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3: b = 8'h38;
            4'd4:    b = 8'h08;
            4'd5:    b = OP_CLEAR;
            4'd6:    b = 8'h06;
            default: b = 8'h0C;
        endcase
        return b;
    endfunction

    // Entry is {nibble_only, byte}; a nibble-only entry carries its nibble in [7:4].
    function automatic logic [8:0] init_rom_4(input logic [3:0] idx);
        logic [8:0] e;
        case (idx)
            4'd0, 4'd1, 4'd2: e = {1'b1, 8'h30};
            4'd3:    e = {1'b1, 8'h20};
            4'd4:    e = {1'b0, 8'h28};
            4'd5:    e = {1'b0, 8'h08};
            4'd6:    e = {1'b0, OP_CLEAR};
            4'd7:    e = {1'b0, 8'h06};
            default: e = {1'b0, 8'h0C};
        endcase
        return e;
    endfunction

    // Clear and return-home are the only commands needing the long execution delay.
    function automatic logic is_clear_home(input logic rs, input logic [7:0] d);
        return !rs && (d[7:2] == 6'd0) && (d != 8'h00);
    endfunction

    function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned clk_hz);
        return 32'((64'(us) * 64'(clk_hz) + 64'd999_999) / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Down-counter delay: done is high N cycles after loading N (a load of 0 behaves as 1).
// Reset preloads RST_VAL so the power-on wait starts without an explicit load.
module lcd_delay_timer #(
    parameter int unsigned    W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= RST_VAL;
        else if (i_load)
            r_cnt <= (i_load_val == '0) ? W'(1) : i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_done = (r_cnt <= W'(1));

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// HD44780 write-path sequencer: power-on init from ROM, then client bytes, each followed
// by the controller execution delay. Define LCD_4BIT_EN for the 4-bit (two-nibble) interface.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned T_PWRON_US = 15000,
    parameter int unsigned T_FS1_US   = 4100,
    parameter int unsigned T_CMD_US   = 40,
    parameter int unsigned T_CLEAR_US = 1640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_init_done,
    output logic       o_wc_wr_enable,
    output logic       o_wc_reg_sel,
    input  logic       i_wc_wr_finish,
    output logic [7:0] o_lcd_db
);

    localparam int unsigned C_PWRON = us_to_cycles(T_PWRON_US, CLK_HZ);
    localparam int unsigned C_FS1   = us_to_cycles(T_FS1_US, CLK_HZ);
    localparam int unsigned C_CMD   = us_to_cycles(T_CMD_US, CLK_HZ);
    localparam int unsigned C_CLEAR = us_to_cycles(T_CLEAR_US, CLK_HZ);
    localparam int unsigned C_M1    = (C_PWRON > C_FS1) ? C_PWRON : C_FS1;
    localparam int unsigned C_M2    = (C_CMD > C_CLEAR) ? C_CMD : C_CLEAR;
    localparam int unsigned C_MAX   = (C_M1 > C_M2) ? C_M1 : C_M2;
    localparam int unsigned TW      = $clog2(C_MAX + 1);
`ifdef LCD_4BIT_EN
    localparam logic [3:0]  INIT_LAST = 4'(INIT_LEN_4 - 1);
`else
    localparam logic [3:0]  INIT_LAST = 4'(INIT_LEN_8 - 1);
`endif

    state_t        r_state, w_next;
    logic [3:0]    r_rom_idx;
    logic          r_req_rs, r_cur_rs, r_rs;
    logic [7:0]    r_req_data, r_cur_byte, r_db;
    logic          r_init_done, r_ready, r_wr_en;
    logic          w_tmr_load, w_tmr_done, w_last_nib, w_src_rs;
    logic [TW-1:0] w_tmr_val;
    logic [7:0]    w_rom_byte, w_src_byte;

`ifdef LCD_4BIT_EN
    logic [8:0]    w_rom;
    logic          w_src_nib;
    logic          r_lo;        // current strobe is the final one of this entry
    assign w_rom      = init_rom_4(r_rom_idx);
    assign w_rom_byte = w_rom[7:0];
    assign w_src_nib  = r_init_done ? 1'b0 : w_rom[8];
    assign w_last_nib = r_lo;
`else
    assign w_rom_byte = init_rom_8(r_rom_idx);
    assign w_last_nib = 1'b1;
`endif

    assign w_src_rs   = r_init_done ? r_req_rs : 1'b0;
    assign w_src_byte = r_init_done ? r_req_data : w_rom_byte;
    assign w_tmr_load = (r_state == S_WAIT_FIN) && i_wc_wr_finish;

    // Delay is chosen from the byte actually written, so ROM and client clears match.
    always_comb begin
        w_tmr_val = TW'(C_CMD);
        if (!w_last_nib)
            w_tmr_val = TW'(C_CMD);
        else if (!r_init_done && r_rom_idx == 4'd0)
            w_tmr_val = TW'(C_FS1);
        else if (is_clear_home(r_cur_rs, r_cur_byte))
            w_tmr_val = TW'(C_CLEAR);
    end

    lcd_delay_timer #(
        .W       (TW),
        .RST_VAL (TW'(C_PWRON))
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_PWR_WAIT: if (w_tmr_done) w_next = S_LOAD;
            S_LOAD:     w_next = S_STROBE;
`ifdef LCD_4BIT_EN
            S_NIB2:     w_next = S_STROBE;
`endif
            S_STROBE:   w_next = S_WAIT_FIN;
            S_WAIT_FIN: if (i_wc_wr_finish) w_next = S_DELAY;
            S_DELAY: begin
                if (w_tmr_done) begin
`ifdef LCD_4BIT_EN
                    if (!w_last_nib)
                        w_next = S_NIB2;
                    else
`endif
                    if (r_init_done || r_rom_idx == INIT_LAST)
                        w_next = S_IDLE;
                    else
                        w_next = S_LOAD;
                end
            end
            S_IDLE:     if (i_req_valid) w_next = S_LOAD;
            default:    w_next = S_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_PWR_WAIT;
            r_rom_idx   <= 4'd0;
            r_init_done <= 1'b0;
            r_ready     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rs        <= 1'b0;
            r_db        <= 8'h00;
            r_req_rs    <= 1'b0;
            r_req_data  <= 8'h00;
            r_cur_rs    <= 1'b0;
            r_cur_byte  <= 8'h00;
`ifdef LCD_4BIT_EN
            r_lo        <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
            r_wr_en <= (w_next == S_STROBE);
            if (r_state == S_IDLE && i_req_valid) begin
                r_req_rs   <= i_req_rs;
                r_req_data <= i_req_data;
            end
            if (r_state == S_LOAD) begin
                r_cur_rs   <= w_src_rs;
                r_cur_byte <= w_src_byte;
                r_rs       <= w_src_rs;
`ifdef LCD_4BIT_EN
                r_db       <= {w_src_byte[7:4], 4'h0};
                r_lo       <= w_src_nib;
`else
                r_db       <= w_src_byte;
`endif
            end
`ifdef LCD_4BIT_EN
            if (r_state == S_NIB2) begin
                r_db <= {r_cur_byte[3:0], 4'h0};
                r_lo <= 1'b1;
            end
`endif
            if (r_state == S_DELAY && w_tmr_done && w_last_nib && !r_init_done) begin
                if (r_rom_idx == INIT_LAST)
                    r_init_done <= 1'b1;
                else
                    r_rom_idx <= r_rom_idx + 4'd1;
            end
        end
    end

    assign o_req_ready    = r_ready;
    assign o_init_done    = r_init_done;
    assign o_wc_wr_enable = r_wr_en;
    assign o_wc_reg_sel   = r_rs;
    assign o_lcd_db       = r_db;

endmodule
